// File: rtl/pool_window_buffer.sv
// pool_window_buffer
//   Line-buffer stage in front of the pooling unit. Takes the row-major
//   feature-map stream from the systolic array and regroups it into
//   non-overlapping 2x2 windows (stride 2). One full row is held in the line
//   buffer so that each bottom-right pixel completes a window immediately.
//
// Ports
//   clk, nrst        clock, synchronous active-low reset
//   start            one-cycle pulse; latches cfg_cols/cfg_rows while idle
//   cfg_cols         frame width, 2..MAX_COLS
//   cfg_rows         frame height, 2..MAX_ROWS
//   in_valid/ready   pixel stream handshake, in_data row-major
//   win_valid/ready  window handshake towards the pooling unit
//   win_tl/tr/bl/br  window pixels (top-left, top-right, bottom-left, bottom-right)
//   busy             frame in progress
//   done             one-cycle pulse when the frame has fully drained
//   win_cnt          windows handed off in the current/last frame
//                    (present only when POOL_WIN_CNT_EN is defined)
//
// State | meaning
//   IDLE    | waiting for start
//   ROW_TOP | even row: pixels go into the line buffer
//   ROW_BOT | odd row: even col -> hold_left, odd col -> emit a window
//   DRAIN   | every pixel accepted, last window still waiting for win_ready

module pool_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_COLS   = 32,
  parameter int MAX_ROWS   = 32
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            start,
  input  logic [$clog2(MAX_COLS+1)-1:0]   cfg_cols,
  input  logic [$clog2(MAX_ROWS+1)-1:0]   cfg_rows,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [DATA_WIDTH-1:0]           win_tl,
  output logic [DATA_WIDTH-1:0]           win_tr,
  output logic [DATA_WIDTH-1:0]           win_bl,
  output logic [DATA_WIDTH-1:0]           win_br,
`ifdef POOL_WIN_CNT_EN
  output logic [$clog2((MAX_COLS/2)*(MAX_ROWS/2)+1)-1:0] win_cnt,
`endif
  output logic                            busy,
  output logic                            done
);

  localparam int CW = $clog2(MAX_COLS+1);
  localparam int RW = $clog2(MAX_ROWS+1);
  localparam int AW = $clog2(MAX_COLS);

  localparam logic [CW-1:0] COL_ONE = CW'(1);
  localparam logic [RW-1:0] ROW_ONE = RW'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_TOP = 2'd1,
    ROW_BOT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state;

  logic [CW-1:0]         cols_q;
  logic [RW-1:0]         rows_q;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] linebuf [MAX_COLS];

  logic [AW-1:0] col_idx;
  logic          accept;
  logic          consume;
  logic          col_last;
  logic          row_last;
  logic          win_load;
  logic          win_valid_nxt;

  assign col_idx  = col[AW-1:0];
  assign busy     = (state != IDLE);
  // Only combinational input->output path: win_ready frees the window slot.
  assign in_ready = ((state == ROW_TOP) || (state == ROW_BOT)) && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = win_valid && win_ready;
  assign col_last = (col == (cols_q - COL_ONE));
  assign row_last = (row == (rows_q - ROW_ONE));

  // Odd col of an odd row is always a bottom-right pixel; a trailing odd
  // column or row never reaches this branch, so those pixels are dropped.
  assign win_load      = accept && (state == ROW_BOT) && col[0];
  assign win_valid_nxt = win_load || (win_valid && !win_ready);

  // Line buffer is deliberately not reset; it is always rewritten by the
  // top row before being read.
  always_ff @(posedge clk) begin
    if (nrst && accept && (state == ROW_TOP)) begin
      linebuf[col_idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      cols_q    <= '0;
      rows_q    <= '0;
      col       <= '0;
      row       <= '0;
      hold_left <= '0;
      win_valid <= 1'b0;
      win_tl    <= '0;
      win_tr    <= '0;
      win_bl    <= '0;
      win_br    <= '0;
      done      <= 1'b0;
`ifdef POOL_WIN_CNT_EN
      win_cnt   <= '0;
`endif
    end else begin
      done      <= 1'b0;
      win_valid <= win_valid_nxt;

      if (win_load) begin
        win_tl <= linebuf[col_idx - IDX_ONE];
        win_tr <= linebuf[col_idx];
        win_bl <= hold_left;
        win_br <= in_data;
      end

      if (accept && (state == ROW_BOT) && !col[0]) begin
        hold_left <= in_data;
      end

`ifdef POOL_WIN_CNT_EN
      if ((state == IDLE) && start) begin
        win_cnt <= '0;
      end else if (consume) begin
        win_cnt <= win_cnt + 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (start) begin
            cols_q <= cfg_cols;
            rows_q <= cfg_rows;
            col    <= '0;
            row    <= '0;
            state  <= ROW_TOP;
          end
        end
        ROW_TOP, ROW_BOT: begin
          if (accept) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row <= '0;
                // A window loaded or still pending on this edge must be
                // handed off before the frame may report done.
                if (win_valid_nxt) begin
                  state <= DRAIN;
                end else begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
              end else begin
                row   <= row + 1'b1;
                state <= (state == ROW_TOP) ? ROW_BOT : ROW_TOP;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (consume) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
